// File: rtl/regfile_mp_sb_pkg.sv
// Shared defaults and types for the multi-port register file and its scoreboard.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);
    localparam int ZERO_ADDR = 0;

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Read/write/issue bus of the multi-port register file; master drives addresses, data and strobes.
interface regfile_mp_sb_if #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
);
    localparam int AW = $clog2(NREGS);

    logic [NUM_RD-1:0][AW-1:0]   rd_addr;
    logic [NUM_RD-1:0][XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]           rd_busy;
    logic [NUM_WR-1:0]           wr_en;
    logic [NUM_WR-1:0][AW-1:0]   wr_addr;
    logic [NUM_WR-1:0][XLEN-1:0] wr_data;
    logic                        iss_en;
    logic [AW-1:0]               iss_addr;
    logic [NREGS-1:0]            busy_vec;
    logic                        any_busy;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy, busy_vec, any_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy, busy_vec, any_busy
    );
endinterface

// File: rtl/regfile_mp_sb_scoreboard.sv
// Per-register busy flops: writeback clears, issue sets, and set beats clear on the same address.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_WR-1:0]         wr_en,
    input  logic [NUM_WR-1:0][AW-1:0] wr_addr,
    input  logic                      iss_en,
    input  logic [AW-1:0]             iss_addr,
    output logic [NREGS-1:0]          busy_vec,
    output logic                      any_busy
);

    logic [NREGS-1:0] busy_nxt;

    always_comb begin
        busy_nxt = busy_vec;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j]) busy_nxt[wr_addr[j]] = 1'b0;
        end
        if (iss_en && !((ZERO_REG != 0) && (iss_addr == AW'(ZERO_ADDR))))
            busy_nxt[iss_addr] = 1'b1;
        if (ZERO_REG != 0) busy_nxt[ZERO_ADDR] = 1'b0;
    end

    // any_busy is its own flop so drain logic never sees a combinational input path
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_vec <= '0;
            any_busy <= 1'b0;
        end else begin
            busy_vec <= busy_nxt;
            any_busy <= |busy_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Parametrised multi-port register file with busy scoreboard.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    regfile_mp_sb_if.slave  bus
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy_q;
    logic             any_q;

    // Later ports overwrite earlier ones in the loop, giving highest-index priority
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREGS; k++) regs[k] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (bus.wr_en[j] && !((ZERO_REG != 0) && (bus.wr_addr[j] == AW'(ZERO_ADDR))))
                    regs[bus.wr_addr[j]] <= bus.wr_data[j];
            end
        end
    end

    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            bus.rd_data[i] = regs[bus.rd_addr[i]];
            bus.rd_busy[i] = busy_q[bus.rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NUM_WR; j++) begin
                if (bus.wr_en[j] && (bus.wr_addr[j] == bus.rd_addr[i])) begin
                    bus.rd_data[i] = bus.wr_data[j];
                    bus.rd_busy[i] = bus.iss_en && (bus.iss_addr == bus.rd_addr[i]);
                end
            end
`endif
            if ((ZERO_REG != 0) && (bus.rd_addr[i] == AW'(ZERO_ADDR))) begin
                bus.rd_data[i] = '0;
                bus.rd_busy[i] = 1'b0;
            end
        end
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .iss_en   (bus.iss_en),
        .iss_addr (bus.iss_addr),
        .busy_vec (busy_q),
        .any_busy (any_q)
    );

    assign bus.busy_vec = busy_q;
    assign bus.any_busy = any_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb (2 read ports, 2 write ports, 32x32, zero register on).
module tb_regfile_mp_sb;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_mp_sb_if #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2)) bus ();

    regfile_mp_sb #(
        .XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en  = '0;
        bus.iss_en = 1'b0;
    endtask

    task automatic wr0(input reg_addr_t a, input xlen_t d);
        bus.wr_en[0]   = 1'b1;
        bus.wr_addr[0] = a;
        bus.wr_data[0] = d;
    endtask

    initial begin
        bus.rd_addr  = '0;
        bus.wr_en    = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.iss_en   = 1'b0;
        bus.iss_addr = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        bus.rd_addr[0] = 5'd5;
        bus.rd_addr[1] = 5'd31;
        #1;
        chk("rst_rd0", bus.rd_data[0], 32'h0);
        chk("rst_rd1", bus.rd_data[1], 32'h0);
        chk("rst_busy_vec", bus.busy_vec, 32'h0);
        chk("rst_any_busy", {31'b0, bus.any_busy}, 32'h0);

        // Basic write / read
        wr0(5'd5, 32'hDEADBEEF);
        tick();
        idle();
        bus.rd_addr[1] = 5'd5;
        #1;
        chk("wr5_rd1", bus.rd_data[1], 32'hDEADBEEF);
        chk("wr5_busy", {31'b0, bus.rd_busy[1]}, 32'h0);

        // Write to register 0 is dropped
        wr0(5'd0, 32'h1234);
        tick();
        idle();
        bus.rd_addr[0] = 5'd0;
        #1;
        chk("wr0_dropped", bus.rd_data[0], 32'h0);

        // Two ports same address: port 1 wins
        bus.wr_en = 2'b11;
        bus.wr_addr[0] = 5'd7; bus.wr_data[0] = 32'h11;
        bus.wr_addr[1] = 5'd7; bus.wr_data[1] = 32'h22;
        tick();
        idle();
        bus.rd_addr[0] = 5'd7;
        #1;
        chk("conflict_r7", bus.rd_data[0], 32'h22);

        // Issue sets busy
        bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
        tick();
        idle();
        bus.rd_addr[0] = 5'd9;
        #1;
        chk("iss9_busy_vec", bus.busy_vec, 32'h0000_0200);
        chk("iss9_any", {31'b0, bus.any_busy}, 32'h1);
        chk("iss9_rd_busy", {31'b0, bus.rd_busy[0]}, 32'h1);

        // Writeback clears busy
        wr0(5'd9, 32'h99);
        tick();
        idle();
        #1;
        chk("wb9_busy_vec", bus.busy_vec, 32'h0);
        chk("wb9_any", {31'b0, bus.any_busy}, 32'h0);
        chk("wb9_data", bus.rd_data[0], 32'h99);

        // Issue + write same address in one cycle: stays busy
        bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
        tick();
        bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
        wr0(5'd9, 32'hA5);
        #1;
        chk("isswr9_same_busy", {31'b0, bus.rd_busy[0]}, 32'h1);
`ifdef REGFILE_BYPASS_EN
        chk("isswr9_same_data", bus.rd_data[0], 32'hA5);
`else
        chk("isswr9_same_data", bus.rd_data[0], 32'h99);
`endif
        tick();
        idle();
        #1;
        chk("isswr9_busy_vec", bus.busy_vec, 32'h0000_0200);
        chk("isswr9_data", bus.rd_data[0], 32'hA5);
        wr0(5'd9, 32'hA6);
        tick();
        idle();

        // Issue to register 0 is ignored
        bus.iss_en = 1'b1; bus.iss_addr = 5'd0;
        tick();
        idle();
        #1;
        chk("iss0_busy_vec", bus.busy_vec, 32'h0);
        chk("iss0_any", {31'b0, bus.any_busy}, 32'h0);

        // Bypass: same-cycle read of a register being written
        wr0(5'd3, 32'h1111);
        tick();
        bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
        wr0(5'd3, 32'hCAFE);
        bus.rd_addr[0] = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_same_data", bus.rd_data[0], 32'hCAFE);
`else
        chk("byp_same_data", bus.rd_data[0], 32'h1111);
`endif
        tick();
        idle();
        #1;
        chk("byp_next_data", bus.rd_data[0], 32'hCAFE);
        chk("byp_r3_busy", {31'b0, bus.rd_busy[0]}, 32'h1);

        // Writeback to busy reg 3: bypass hides busy, non-bypass shows pre-edge busy
        wr0(5'd3, 32'hBEEF);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_wb_busy", {31'b0, bus.rd_busy[0]}, 32'h0);
`else
        chk("byp_wb_busy", {31'b0, bus.rd_busy[0]}, 32'h1);
`endif
        tick();
        idle();
        #1;
        chk("wb3_busy_vec", bus.busy_vec, 32'h0);

        // Reset priority over write and issue; leave reg 12 busy beforehand
        wr0(5'd4, 32'h44);
        bus.iss_en = 1'b1; bus.iss_addr = 5'd12;
        tick();
        idle();
        bus.rd_addr[0] = 5'd4;
        #1;
        chk("pre_rst_r4", bus.rd_data[0], 32'h44);
        chk("pre_rst_any", {31'b0, bus.any_busy}, 32'h1);
        rst = 1'b1;
        wr0(5'd4, 32'hFF);
        bus.iss_en = 1'b1; bus.iss_addr = 5'd4;
        tick();
        rst = 1'b0;
        idle();
        bus.rd_addr[1] = 5'd5;
        #1;
        chk("rstp_r4", bus.rd_data[0], 32'h0);
        chk("rstp_r5", bus.rd_data[1], 32'h0);
        chk("rstp_busy_vec", bus.busy_vec, 32'h0);
        chk("rstp_any", {31'b0, bus.any_busy}, 32'h0);
        bus.rd_addr[0] = 5'd7;
        #1;
        chk("rstp_r7", bus.rd_data[0], 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
